rom_load_ctrl: RTL and testbench
================================

Name: rom_load_ctrl

Overview:
- Sequences the instruction-ROM write port during a UART program download.
- Accepts bytes from the UART byte receiver and packs them little-endian into 32-bit words.
- Issues single-cycle ROM writes at consecutive word addresses.
- Holds the core in reset while loading and releases it when the byte stream goes idle. Sits between the debug button debouncer, UART receiver, ROM and core reset.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first loaded word (word aligned).
- DEPTH_WORDS, 4096, ROM capacity in words; writes beyond it are dropped.
- IDLE_TIMEOUT, 1_000_000, clk cycles without rx_valid_i (after the first byte) that end the load.
- CNT_W, 16, width of the word counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- load_req_i  in  1  single-cycle pulse from the debouncer; starts a load
- rx_valid_i  in  1  single-cycle strobe, one received byte
- rx_data_i  in  8  received byte
- rom_wen_o  out  1  ROM write strobe, one cycle per word
- rom_addr_o  out  32  ROM byte write address
- rom_data_o  out  32  ROM write data
- cpu_hold_o  out  1  1 = core held in reset
- busy_o  out  1  load in progress
- done_o  out  1  one-cycle pulse at load completion
- err_o  out  1  sticky overflow flag, cleared by next load_req_i
- word_cnt_o  out  CNT_W  words accepted in the current/last load
- csum_o  out  8  byte checksum (see Optional Feature)

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - rom_wen_o=0, rom_addr_o=BASE_ADDR, rom_data_o=0.
  - cpu_hold_o=0, busy_o=0, done_o=0, err_o=0, word_cnt_o=0, csum_o=0.
  - Byte index=0, timer=0.
- States: IDLE, ARM, RECV, FLUSH, DONE.
- IDLE -> ARM on load_req_i.
  - Clear word_cnt_o, err_o, byte index, csum_o; set rom_addr_o=BASE_ADDR.
  - cpu_hold_o=1 and busy_o=1 from the next cycle, held through DONE.
- ARM: waits indefinitely for the first byte; no timeout. The first rx_valid_i captures the byte and moves to RECV.
- RECV, each rx_valid_i:
  - Byte written to lane byte_idx (byte 0 -> bits[7:0]); byte_idx increments mod 4; timer cleared.
  - On the 4th byte: rom_data_o gets the assembled word and rom_wen_o=1 for the next cycle only. The address is the current word address.
  - rom_addr_o advances by 4 and word_cnt_o increments one cycle after the strobe.
  - A byte arriving in the cycle rom_wen_o is high is still captured (no lost bytes). Byte-to-byte spacing may be as low as 1 cycle.
- Timer: increments every RECV cycle without rx_valid_i. When timer == IDLE_TIMEOUT-1:
  - byte_idx != 0 -> FLUSH.
  - Otherwise -> DONE.
- FLUSH: one-cycle write of the partial word, unfilled upper lanes zero, then DONE.
- DONE: one cycle.
  - done_o=1, rom_wen_o=0.
  - cpu_hold_o and busy_o deassert in the same cycle state returns to IDLE, so the core leaves reset at PC start with the ROM fully written.
- Overflow: when word_cnt_o == DEPTH_WORDS, further completed words set err_o=1.
  - rom_wen_o is suppressed; address and count freeze; the load continues to consume bytes until timeout.
- load_req_i while busy: ignored.
- Reset mid-load: returns to IDLE immediately; cpu_hold_o drops; a partial ROM image remains.
- word_cnt_o saturates at 2^CNT_W-1.

Optional Feature:
- Macro: ROM_LOAD_CSUM_EN.
- Defined:
  - csum_o is an 8-bit mod-256 running sum of every accepted byte, including bytes dropped on overflow.
  - Cleared on load_req_i; valid from the DONE cycle and held until the next load.
- Undefined: csum_o tied to 8'h00; no adder is synthesised.

Decomposition:
- Shared package rom_load_pkg:
  - State encoding localparams: IDLE=0, ARM=1, RECV=2, FLUSH=3, DONE=4, 3 bits.
  - BYTES_PER_WORD=4; ADDR_STEP=4.
- One natural sub-module: rom_load_packer.
  - Byte lane steering, byte index and word-complete strobe.
  - Also hosts the checksum when enabled.
- The FSM, timer and address/count stay in the top.

Test Plan:
- Basic load: load_req_i; bytes 78 56 34 12 EF BE AD DE, 10 cycles apart; then silence.
  - rom_wen_o at 0x0 with 0x12345678 and at 0x4 with 0xDEADBEEF.
  - After IDLE_TIMEOUT (set to 50): done_o pulses, word_cnt_o=2, cpu_hold_o falls.
- Partial word: 5 bytes 01 02 03 04 AA, then timeout.
  - Writes 0x04030201 @0x0, then FLUSH writes 0x000000AA @0x4; word_cnt_o=2.
- Back-to-back bytes: rx_valid_i on 8 consecutive cycles.
  - Two writes, no byte lost.
  - The 5th byte, arriving in the cycle of the first strobe, lands in lane 0 of word 2.
- Overflow: DEPTH_WORDS=2, 12 bytes.
  - Exactly two writes; err_o=1 at done; word_cnt_o=2.
  - Next load_req_i clears err_o.
- Reset and re-request:
  - rst low after 2 words -> all outputs reset values, cpu_hold_o=0.
  - load_req_i during RECV -> ignored, count continues.
- With ROM_LOAD_CSUM_EN: bytes FF 01 10 20 -> csum_o=0x30 at done. Without the macro, csum_o stays 0x00.

Source files
------------

// File: rtl/rom_load_pkg.sv
// rom_load_pkg: shared state encoding and word geometry for the ROM loader.
// Checksum logic is built only when ROM_LOAD_CSUM_EN is defined.
package rom_load_pkg;

  localparam int unsigned ST_W           = 3;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned IDX_W          = $clog2(BYTES_PER_WORD);
  localparam logic [31:0] ADDR_STEP      = 32'd4;

  typedef enum logic [ST_W-1:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    RECV  = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/rom_load_packer.sv
// rom_load_packer: little-endian byte lane steering into 32-bit words.
// Hosts the running byte checksum when ROM_LOAD_CSUM_EN is defined.
module rom_load_packer
  import rom_load_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             accept_i,
  input  logic [7:0]       byte_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             cplt_o,
  output logic [31:0]      word_o,
  output logic [7:0]       csum_o
);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      word_q, word_d;

  // lane 0 restarts the word so a flushed partial has zero upper lanes
  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    if (clr_i) begin
      idx_d  = '0;
      word_d = '0;
    end else if (accept_i) begin
      if (idx_q == '0) begin
        word_d = {24'h0, byte_i};
      end else begin
        word_d[{idx_q, 3'b000} +: 8] = byte_i;
      end
      idx_d = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

  assign idx_o  = idx_q;
  assign word_o = word_d;
  assign cplt_o = accept_i &
                  (idx_q == IDX_W'(BYTES_PER_WORD - 1));

`ifdef ROM_LOAD_CSUM_EN
  logic [7:0] csum_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csum_q <= 8'h00;
    end else if (clr_i) begin
      csum_q <= 8'h00;
    end else if (accept_i) begin
      csum_q <= csum_q + byte_i;
    end
  end

  assign csum_o = csum_q;
`else
  assign csum_o = 8'h00;
`endif

endmodule

// File: rtl/rom_load_ctrl.sv
// rom_load_ctrl: UART program download into instruction ROM, core held in reset.
// Define ROM_LOAD_CSUM_EN to enable the byte checksum on csum_o.
module rom_load_ctrl
  import rom_load_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS  = 4096,
  parameter int unsigned IDLE_TIMEOUT = 1_000_000,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_req_i,
  input  logic             rx_valid_i,
  input  logic [7:0]       rx_data_i,
  output logic             rom_wen_o,
  output logic [31:0]      rom_addr_o,
  output logic [31:0]      rom_data_o,
  output logic             cpu_hold_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [CNT_W-1:0] word_cnt_o,
  output logic [7:0]       csum_o
);

  localparam int unsigned TMR_W = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST =
    TMR_W'(IDLE_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             wen_q, wen_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic             clr;
  logic             accept;
  logic             wr_req;
  logic             full;
  logic             cplt;
  logic [IDX_W-1:0] idx;
  logic [31:0]      word;

  rom_load_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (clr),
    .accept_i (accept),
    .byte_i   (rx_data_i),
    .idx_o    (idx),
    .cplt_o   (cplt),
    .word_o   (word),
    .csum_o   (csum_o)
  );

  assign full = 32'(cnt_q) >= 32'(DEPTH_WORDS);

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    wen_d   = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    clr     = 1'b0;
    accept  = 1'b0;
    wr_req  = 1'b0;

    // address/count follow the strobe by one cycle
    if (wen_q) begin
      addr_d = addr_q + ADDR_STEP;
      if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    unique case (state_q)
      IDLE: begin
        if (load_req_i) begin
          state_d = ARM;
          clr     = 1'b1;
          cnt_d   = '0;
          err_d   = 1'b0;
          addr_d  = BASE_ADDR;
          tmr_d   = '0;
        end
      end
      ARM: begin
        accept = rx_valid_i;
        if (rx_valid_i) begin
          state_d = RECV;
        end
      end
      RECV: begin
        accept = rx_valid_i;
        wr_req = cplt;
        if (rx_valid_i) begin
          tmr_d = '0;
        end else if (tmr_q == TMR_LAST) begin
          tmr_d = '0;
          if (idx != '0) begin
            state_d = FLUSH;
            wr_req  = 1'b1;
          end else begin
            state_d = DONE;
          end
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      FLUSH: state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (wr_req) begin
      if (full) begin
        err_d = 1'b1;
      end else begin
        wen_d  = 1'b1;
        data_d = word;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      wen_q   <= 1'b0;
      addr_q  <= BASE_ADDR;
      data_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign rom_wen_o  = wen_q;
  assign rom_addr_o = addr_q;
  assign rom_data_o = data_q;
  assign busy_o     = state_q != IDLE;
  assign cpu_hold_o = state_q != IDLE;
  assign done_o     = state_q == DONE;
  assign err_o      = err_q;
  assign word_cnt_o = cnt_q;

endmodule

// File: tb/tb_rom_load_ctrl.sv
// tb_rom_load_ctrl: randomized checks of the ROM loader against a byte-list model.
// Two instances: a roomy ROM and a 2-word ROM that overflows.
module tb_rom_load_ctrl;

  localparam int TMO   = 50;
  localparam int DEP_A = 64;
  localparam int DEP_B = 2;
  localparam logic [31:0] BASE_A = 32'h0000_0000;
  localparam logic [31:0] BASE_B = 32'h0000_0100;
`ifdef ROM_LOAD_CSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  typedef logic [7:0]  byte_q_t[$];
  typedef logic [63:0] wr_q_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_req_i = 1'b0;
  logic        rx_valid_i = 1'b0;
  logic [7:0]  rx_data_i = 8'h00;

  logic        wen_a, hold_a, busy_a, done_a, err_a;
  logic [31:0] addr_a, data_a;
  logic [15:0] cnt_a;
  logic [7:0]  cs_a;
  logic        wen_b, hold_b, busy_b, done_b, err_b;
  logic [31:0] addr_b, data_b;
  logic [15:0] cnt_b;
  logic [7:0]  cs_b;

  int checks = 0;
  int errors = 0;

  wr_q_t       wq_a, wq_b;
  bit          dn_a, dn_b;
  logic [15:0] dn_cnt_a, dn_cnt_b;
  logic        dn_err_a, dn_err_b, dn_hold_a;
  logic [7:0]  dn_cs_a, dn_cs_b;
  logic        req_busy_a, post_hold_a, post_busy_a;

  rom_load_ctrl #(
    .BASE_ADDR(BASE_A), .DEPTH_WORDS(DEP_A),
    .IDLE_TIMEOUT(TMO), .CNT_W(16)
  ) u_a (
    .clk(clk), .rst(rst), .load_req_i(load_req_i),
    .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i),
    .rom_wen_o(wen_a), .rom_addr_o(addr_a),
    .rom_data_o(data_a), .cpu_hold_o(hold_a),
    .busy_o(busy_a), .done_o(done_a), .err_o(err_a),
    .word_cnt_o(cnt_a), .csum_o(cs_a)
  );

  rom_load_ctrl #(
    .BASE_ADDR(BASE_B), .DEPTH_WORDS(DEP_B),
    .IDLE_TIMEOUT(TMO), .CNT_W(16)
  ) u_b (
    .clk(clk), .rst(rst), .load_req_i(load_req_i),
    .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i),
    .rom_wen_o(wen_b), .rom_addr_o(addr_b),
    .rom_data_o(data_b), .cpu_hold_o(hold_b),
    .busy_o(busy_b), .done_o(done_b), .err_o(err_b),
    .word_cnt_o(cnt_b), .csum_o(cs_b)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wen_a) wq_a.push_back({addr_a, data_a});
    if (wen_b) wq_b.push_back({addr_b, data_b});
    if (done_a) begin
      dn_a = 1'b1; dn_cnt_a = cnt_a; dn_err_a = err_a;
      dn_cs_a = cs_a; dn_hold_a = hold_a;
    end
    if (done_b) begin
      dn_b = 1'b1; dn_cnt_b = cnt_b;
      dn_err_b = err_b; dn_cs_b = cs_b;
    end
  end

  // expected ROM image from the byte list alone
  task automatic model(input byte_q_t b, input int depth,
                       input logic [31:0] base, output wr_q_t w,
                       output int cnt, output bit err,
                       output logic [7:0] cs);
    int nw;
    logic [31:0] wd;
    w.delete();
    cs = 8'h00;
    nw = (b.size() + 3) / 4;
    foreach (b[i]) cs = cs + b[i];
    for (int k = 0; k < nw; k++) begin
      wd = '0;
      for (int j = 0; j < 4; j++)
        if (4 * k + j < b.size())
          wd = wd | (32'(b[4 * k + j]) << (8 * j));
      if (k < depth) w.push_back({base + 32'(4 * k), wd});
    end
    cnt = (nw < depth) ? nw : depth;
    err = nw > depth;
    if (!CSUM_ON) cs = 8'h00;
  endtask

  task automatic send_byte(input logic [7:0] v);
    rx_valid_i = 1'b1;
    rx_data_i  = v;
    @(posedge clk); #1;
    rx_valid_i = 1'b0;
  endtask

  task automatic pulse_req();
    @(posedge clk); #1 load_req_i = 1'b1;
    @(posedge clk); #1 load_req_i = 1'b0;
  endtask

  task automatic wait_done(output bit to);
    int c = 0;
    while (!(dn_a && dn_b) && c < 400) begin
      @(posedge clk); c++;
    end
    to = !(dn_a && dn_b);
    #1;
    post_hold_a = hold_a;
    post_busy_a = busy_a;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic drive_load(input byte_q_t b, input int glo,
                            input int ghi, output bit to);
    wq_a.delete(); wq_b.delete();
    dn_a = 1'b0; dn_b = 1'b0;
    pulse_req();
    req_busy_a = busy_a;
    foreach (b[i]) begin
      repeat ($urandom_range(ghi, glo)) begin
        @(posedge clk); #1;
      end
      send_byte(b[i]);
    end
    wait_done(to);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({wen_a, addr_a, data_a, hold_a, busy_a, done_a,
         err_a, cnt_a, cs_a} !== {1'b0, BASE_A, 32'h0, 5'b0,
         16'h0, 8'h00}) begin
      errors++;
      $display("FAIL reset_a wen=%b addr=%h data=%h hold=%b busy=%b cnt=%0d want all idle",
               wen_a, addr_a, data_a, hold_a, busy_a, cnt_a);
    end
    checks++;
    if ({addr_b, hold_b, err_b, cnt_b} !==
        {BASE_B, 1'b0, 1'b0, 16'h0}) begin
      errors++;
      $display("FAIL reset_b addr=%h hold=%b err=%b cnt=%0d want %h 0 0 0",
               addr_b, hold_b, err_b, cnt_b, BASE_B);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy_a, hold_a, done_a} !== 3'b000) begin
      errors++;
      $display("FAIL idle_after_reset busy/hold/done=%b want 000",
               {busy_a, hold_a, done_a});
    end
  endtask

  task automatic test_basic();
    byte_q_t b = '{8'h78, 8'h56, 8'h34, 8'h12,
                   8'hEF, 8'hBE, 8'hAD, 8'hDE};
    wr_q_t ew; int ec; bit ee; logic [7:0] ecs; bit to;
    model(b, DEP_A, BASE_A, ew, ec, ee, ecs);
    drive_load(b, 9, 9, to);
    checks++;
    if (to) begin errors++; $display("FAIL basic_done got none want pulse"); end
    checks++;
    if (req_busy_a !== 1'b1) begin
      errors++; $display("FAIL basic_busy got %b want 1", req_busy_a);
    end
    checks++;
    if (wq_a.size() != ew.size()) begin
      errors++; $display("FAIL basic_nwr got %0d want %0d", wq_a.size(), ew.size());
    end
    foreach (ew[i]) begin
      checks++;
      if (i >= wq_a.size() || wq_a[i] !== ew[i]) begin
        errors++; $display("FAIL basic_wr%0d got %h want %h", i, wq_a[i], ew[i]);
      end
    end
    checks++;
    if (dn_cnt_a !== 16'(ec) || dn_hold_a !== 1'b1) begin
      errors++;
      $display("FAIL basic_done_state cnt=%0d hold=%b want %0d 1",
               dn_cnt_a, dn_hold_a, ec);
    end
    checks++;
    if (post_hold_a !== 1'b0 || post_busy_a !== 1'b0) begin
      errors++;
      $display("FAIL basic_release hold=%b busy=%b want 0 0",
               post_hold_a, post_busy_a);
    end
  endtask

  task automatic test_partial();
    byte_q_t b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hAA};
    wr_q_t ew; int ec; bit ee; logic [7:0] ecs; bit to;
    model(b, DEP_A, BASE_A, ew, ec, ee, ecs);
    drive_load(b, 1, 6, to);
    checks++;
    if (to || wq_a.size() != ew.size()) begin
      errors++;
      $display("FAIL partial_nwr got %0d timeout=%b want %0d 0",
               wq_a.size(), to, ew.size());
    end
    foreach (ew[i]) begin
      checks++;
      if (i >= wq_a.size() || wq_a[i] !== ew[i]) begin
        errors++; $display("FAIL partial_wr%0d got %h want %h", i, wq_a[i], ew[i]);
      end
    end
    checks++;
    if (dn_cnt_a !== 16'(ec) || dn_err_a !== 1'b0) begin
      errors++;
      $display("FAIL partial_cnt got %0d err=%b want %0d 0", dn_cnt_a, dn_err_a, ec);
    end
  endtask

  task automatic test_back_to_back();
    byte_q_t b;
    wr_q_t ew; int ec; bit ee; logic [7:0] ecs; bit to;
    for (int i = 0; i < 8; i++) b.push_back(8'($urandom));
    model(b, DEP_A, BASE_A, ew, ec, ee, ecs);
    drive_load(b, 0, 0, to);
    checks++;
    if (to || wq_a.size() != ew.size()) begin
      errors++;
      $display("FAIL b2b_nwr got %0d timeout=%b want %0d 0",
               wq_a.size(), to, ew.size());
    end
    foreach (ew[i]) begin
      checks++;
      if (i >= wq_a.size() || wq_a[i] !== ew[i]) begin
        errors++; $display("FAIL b2b_wr%0d got %h want %h", i, wq_a[i], ew[i]);
      end
    end
    checks++;
    if (dn_cs_a !== ecs || dn_cnt_a !== 16'(ec)) begin
      errors++;
      $display("FAIL b2b_done cs=%h cnt=%0d want %h %0d", dn_cs_a, dn_cnt_a, ecs, ec);
    end
  endtask

  task automatic test_overflow();
    byte_q_t b;
    wr_q_t ew; int ec; bit ee; logic [7:0] ecs; bit to;
    for (int i = 0; i < 12; i++) b.push_back(8'($urandom));
    model(b, DEP_B, BASE_B, ew, ec, ee, ecs);
    drive_load(b, 0, 2, to);
    checks++;
    if (to || wq_b.size() != ew.size()) begin
      errors++;
      $display("FAIL ovf_nwr got %0d timeout=%b want %0d 0",
               wq_b.size(), to, ew.size());
    end
    foreach (ew[i]) begin
      checks++;
      if (i >= wq_b.size() || wq_b[i] !== ew[i]) begin
        errors++; $display("FAIL ovf_wr%0d got %h want %h", i, wq_b[i], ew[i]);
      end
    end
    checks++;
    if (dn_err_b !== 1'b1 || dn_cnt_b !== 16'(ec) || dn_cs_b !== ecs) begin
      errors++;
      $display("FAIL ovf_done err=%b cnt=%0d cs=%h want 1 %0d %h",
               dn_err_b, dn_cnt_b, dn_cs_b, ec, ecs);
    end
  endtask

  task automatic test_arm_wait();
    bit to;
    wq_a.delete(); wq_b.delete();
    dn_a = 1'b0; dn_b = 1'b0;
    pulse_req();
    checks++;
    if (err_b !== 1'b0) begin
      errors++; $display("FAIL err_clear got %b want 0", err_b);
    end
    repeat (TMO + 20) @(posedge clk);
    #1;
    checks++;
    if (busy_a !== 1'b1 || dn_a) begin
      errors++;
      $display("FAIL arm_no_timeout busy=%b done_seen=%b want 1 0", busy_a, dn_a);
    end
    send_byte(8'h11); send_byte(8'h22);
    send_byte(8'h33); send_byte(8'h44);
    wait_done(to);
    checks++;
    if (to || wq_b.size() != 1 || wq_b[0] !== {BASE_B, 32'h44332211}) begin
      errors++;
      $display("FAIL arm_load got n=%0d wr=%h want 1 %h",
               wq_b.size(), wq_b[0], {BASE_B, 32'h44332211});
    end
    checks++;
    if (dn_err_b !== 1'b0 || dn_cnt_b !== 16'd1) begin
      errors++;
      $display("FAIL arm_done err=%b cnt=%0d want 0 1", dn_err_b, dn_cnt_b);
    end
  endtask

  task automatic test_csum();
    byte_q_t b = '{8'hFF, 8'h01, 8'h10, 8'h20};
    logic [7:0] want;
    bit to;
    want = CSUM_ON ? 8'h30 : 8'h00;
    drive_load(b, 0, 3, to);
    checks++;
    if (to || dn_cs_a !== want) begin
      errors++;
      $display("FAIL csum got %h timeout=%b want %h", dn_cs_a, to, want);
    end
  endtask

  task automatic test_reset_midload();
    pulse_req();
    for (int i = 0; i < 4; i++) begin
      send_byte(8'($urandom)); @(posedge clk); #1;
    end
    load_req_i = 1'b1;
    @(posedge clk); #1 load_req_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_byte(8'($urandom)); @(posedge clk); #1;
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (cnt_a !== 16'd2 || busy_a !== 1'b1 || addr_a !== 32'h8) begin
      errors++;
      $display("FAIL req_ignored cnt=%0d busy=%b addr=%h want 2 1 8",
               cnt_a, busy_a, addr_a);
    end
    #3 rst = 1'b0;
    #1;
    checks++;
    if ({hold_a, busy_a, wen_a, err_a, cnt_a, addr_a, cs_a} !==
        {4'b0, 16'h0, BASE_A, 8'h00}) begin
      errors++;
      $display("FAIL midload_reset hold=%b busy=%b cnt=%0d addr=%h want 0 0 0 %h",
               hold_a, busy_a, cnt_a, addr_a, BASE_A);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      byte_q_t b;
      wr_q_t ea, eb; int ca, cb; bit ra, rb;
      logic [7:0] sa, sb;
      bit to;
      int len = $urandom_range(20, 1);
      for (int i = 0; i < len; i++) b.push_back(8'($urandom));
      model(b, DEP_A, BASE_A, ea, ca, ra, sa);
      model(b, DEP_B, BASE_B, eb, cb, rb, sb);
      drive_load(b, 0, 3, to);
      checks++;
      if (to || wq_a.size() != ea.size() || wq_b.size() != eb.size()) begin
        errors++;
        $display("FAIL rnd%0d_nwr got %0d/%0d timeout=%b want %0d/%0d",
                 n, wq_a.size(), wq_b.size(), to, ea.size(), eb.size());
      end
      foreach (ea[i]) begin
        checks++;
        if (i >= wq_a.size() || wq_a[i] !== ea[i]) begin
          errors++; $display("FAIL rnd%0d_a_wr%0d got %h want %h", n, i, wq_a[i], ea[i]);
        end
      end
      foreach (eb[i]) begin
        checks++;
        if (i >= wq_b.size() || wq_b[i] !== eb[i]) begin
          errors++; $display("FAIL rnd%0d_b_wr%0d got %h want %h", n, i, wq_b[i], eb[i]);
        end
      end
      checks++;
      if ({dn_cnt_a, dn_err_a, dn_cs_a} !== {16'(ca), ra, sa} ||
          {dn_cnt_b, dn_err_b, dn_cs_b} !== {16'(cb), rb, sb}) begin
        errors++;
        $display("FAIL rnd%0d_done a=%0d/%b/%h b=%0d/%b/%h want a=%0d/%b/%h b=%0d/%b/%h",
                 n, dn_cnt_a, dn_err_a, dn_cs_a, dn_cnt_b, dn_err_b, dn_cs_b,
                 ca, ra, sa, cb, rb, sb);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_back_to_back();
    test_overflow();
    test_arm_wait();
    test_csum();
    test_reset_midload();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
